multiplier_complex_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational complex multiplier used by the FFT butterfly datapath. It multiplies two signed fixed-point complex operands (default Q16.16) and optionally conjugates operand 1, which supports the inverse FFT. The result is rounded to nearest and saturated, with a per-sample overflow flag. The block uses a valid/ready handshake with full-pipeline stall, so it can sit between the twiddle ROM and the butterfly adder under backpressure.

---
 rtl/multiplier_complex_pipe.sv | 177 +++++++++++++++++
 tb/tb_multiplier_complex_pipe.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_complex_pipe.sv
// Pipelined signed fixed-point complex multiplier with optional conjugation
// of operand 1, round-to-nearest (half toward +inf), saturation and a
// per-sample overflow flag. Three register stages behind a valid/ready
// handshake; a stalled output freezes the whole pipeline.
//
// Stage map:
//   S1 : operands and conj bit
//   S2 : the four full-width partial products
//   S3 : combined, rounded, saturated result (drives the outputs directly)
module multiplier_complex_pipe #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             di_valid,
  output logic             di_ready,
  input  logic [WIDTH-1:0] di_real0,
  input  logic [WIDTH-1:0] di_img0,
  input  logic [WIDTH-1:0] di_real1,
  input  logic [WIDTH-1:0] di_img1,
  input  logic             di_conj,
  output logic             do_valid,
  input  logic             do_ready,
  output logic [WIDTH-1:0] do_real,
  output logic [WIDTH-1:0] do_img,
  output logic             do_ovf
);

  // Full product width and the extended width used for the sum/rounding.
  // Two guard bits keep (-max)*(-max) + (-max)*(-max) plus the rounding
  // constant representable without wrap.
  localparam int PW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 2;

  // Rounding constant: one half LSB of the result.
  localparam logic [EW-1:0] RND = {{(EW-1){1'b0}}, 1'b1} << (FRAC - 1);

  // ------------------------------------------------------------------
  // Handshake: the pipeline moves only when the output slot is free or
  // being consumed this cycle. Every stage shares this one enable.
  // ------------------------------------------------------------------
  logic advance;

  assign advance  = !do_valid || do_ready;
  assign di_ready = advance;

  // ------------------------------------------------------------------
  // Stage 1 storage. Operand packing: [0]=ar, [1]=ai, [2]=br, [3]=bi.
  // ------------------------------------------------------------------
  logic                  s1_valid_reg;
  logic                  s1_conj_reg;
  logic [3:0][WIDTH-1:0] s1_op_reg;

  // S1 valid bit: cleared on reset, loads the input valid when advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= di_valid;
    end
  end

  // S1 data: no reset needed, qualified by the valid bit downstream.
  always_ff @(posedge clk) begin
    if (advance) begin
      s1_op_reg   <= {di_img1, di_real1, di_img0, di_real0};
      s1_conj_reg <= di_conj;
    end
  end

  // ------------------------------------------------------------------
  // Partial products. Index map:
  //   [0] = ar*br   [1] = ai*bi   [2] = ar*bi   [3] = ai*br
  // Operands are sign-extended to PW bits; the low PW bits of the
  // extended product are the exact signed product.
  // ------------------------------------------------------------------
  logic [3:0][PW-1:0] prod_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_prod
      // Left factor alternates ar/ai; right factor is br for [0],[3], bi otherwise.
      localparam int LHS = gi % 2;
      localparam int RHS = ((gi == 0) || (gi == 3)) ? 2 : 3;

      logic [PW-1:0] lhs_ext;
      logic [PW-1:0] rhs_ext;

      assign lhs_ext       = {{WIDTH{s1_op_reg[LHS][WIDTH-1]}}, s1_op_reg[LHS]};
      assign rhs_ext       = {{WIDTH{s1_op_reg[RHS][WIDTH-1]}}, s1_op_reg[RHS]};
      assign prod_next[gi] = lhs_ext * rhs_ext;
    end
  endgenerate

  // ------------------------------------------------------------------
  // Stage 2 storage.
  // ------------------------------------------------------------------
  logic               s2_valid_reg;
  logic               s2_conj_reg;
  logic [3:0][PW-1:0] s2_prod_reg;

  // S2 valid bit: follows S1 on advance, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
    end else if (advance) begin
      s2_valid_reg <= s1_valid_reg;
    end
  end

  // S2 data: products and the conj bit travelling with its own sample.
  always_ff @(posedge clk) begin
    if (advance) begin
      s2_prod_reg <= prod_next;
      s2_conj_reg <= s1_conj_reg;
    end
  end

  // ------------------------------------------------------------------
  // Combine, round and saturate. Component [0] is real, [1] imaginary.
  //   real : rr -/+ ii      (subtract unless conjugating)
  //   imag : ir +/- ri      (add unless conjugating)
  // ------------------------------------------------------------------
  logic [1:0][WIDTH-1:0] res_next;
  logic [1:0]            ovf_next;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_comp
      localparam logic IS_RE = (gi == 0);
      localparam int   XI    = (gi == 0) ? 0 : 3;
      localparam int   YI    = (gi == 0) ? 1 : 2;

      logic          sub;
      logic [EW-1:0] x_ext;
      logic [EW-1:0] y_ext;
      logic [EW-1:0] sum;
      logic [EW-1:0] rnd;
      logic [EW-1:0] sh;
      logic          sat_hi;
      logic          sat_lo;

      assign sub   = s2_conj_reg ^ IS_RE;
      assign x_ext = {{2{s2_prod_reg[XI][PW-1]}}, s2_prod_reg[XI]};
      assign y_ext = {{2{s2_prod_reg[YI][PW-1]}}, s2_prod_reg[YI]};
      assign sum   = sub ? (x_ext - y_ext) : (x_ext + y_ext);
      assign rnd   = sum + RND;
      assign sh    = $signed(rnd) >>> FRAC;

      // In range only when every bit from the result sign bit upward matches.
      assign sat_hi = !sh[EW-1] &&  (|sh[EW-2:WIDTH-1]);
      assign sat_lo =  sh[EW-1] && !(&sh[EW-2:WIDTH-1]);

      assign res_next[gi] = sat_hi ? {1'b0, {(WIDTH-1){1'b1}}} :
                            sat_lo ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     sh[WIDTH-1:0];
      assign ovf_next[gi] = sat_hi || sat_lo;
    end
  endgenerate

  // Stage 3 / output register: overflow is forced low on invalid slots so
  // do_ovf never flags a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      do_valid <= 1'b0;
      do_real  <= '0;
      do_img   <= '0;
      do_ovf   <= 1'b0;
    end else if (advance) begin
      do_valid <= s2_valid_reg;
      do_real  <= res_next[0];
      do_img   <= res_next[1];
      do_ovf   <= s2_valid_reg && (|ovf_next);
    end
  end

endmodule

// File: tb/tb_multiplier_complex_pipe.sv
// Directed-vector bench for multiplier_complex_pipe (Q16.16 defaults).
module tb_multiplier_complex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        di_valid;
  logic        di_ready;
  logic [31:0] di_real0, di_img0, di_real1, di_img1;
  logic        di_conj;
  logic        do_valid;
  logic        do_ready;
  logic [31:0] do_real, do_img;
  logic        do_ovf;

  int nvec = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] ar, ai, br, bi;
    logic        cj;
    logic [31:0] er, ei;
    logic        eo;
  } vec_t;

  vec_t vt [12];

  always #5 clk = ~clk;

  multiplier_complex_pipe #(.WIDTH(32), .FRAC(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .di_valid (di_valid),
    .di_ready (di_ready),
    .di_real0 (di_real0),
    .di_img0  (di_img0),
    .di_real1 (di_real1),
    .di_img1  (di_img1),
    .di_conj  (di_conj),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_real  (do_real),
    .do_img   (do_img),
    .do_ovf   (do_ovf)
  );

  // Hand-computed vectors (operand0, operand1, conj, expected re/im/ovf).
  task automatic load_table();
    vt[0]  = '{32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'h0002_0000, 1'b0, 32'h0000_0000, 32'h0004_0000, 1'b0};
    vt[1]  = '{32'h0010_0000, 32'h0000_0000, 32'h0020_0000, 32'h0000_0000, 1'b0, 32'h0200_0000, 32'h0000_0000, 1'b0};
    vt[2]  = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b0, 32'hFFFB_0000, 32'h000A_0000, 1'b0};
    vt[3]  = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000, 1'b1, 32'h000B_0000, 32'h0002_0000, 1'b0};
    vt[4]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vt[5]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[6]  = '{32'h0000_0001, 32'h0000_0000, 32'h0000_7FFF, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vt[7]  = '{32'h7FFF_0000, 32'h0000_0000, 32'h7FFF_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1};
    vt[8]  = '{32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1};
    vt[9]  = '{32'h8000_0000, 32'h0000_0000, 32'h7FFF_0000, 32'h0000_0000, 1'b0, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vt[10] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vt[11] = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    di_valid = 1'b1;
    di_real0 = v.ar;
    di_img0  = v.ai;
    di_real1 = v.br;
    di_img1  = v.bi;
    di_conj  = v.cj;
  endtask

  task automatic idle();
    di_valid = 1'b0;
    di_real0 = '0;
    di_img0  = '0;
    di_real1 = '0;
    di_img1  = '0;
    di_conj  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    do_ready = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;
    nvec++;
    if (do_valid !== 1'b0 || do_ovf !== 1'b0) begin
      nerr++;
      $display("FAIL reset_flags: do_valid=%b do_ovf=%b, required 0 0", do_valid, do_ovf);
    end
    nvec++;
    if (do_real !== 32'h0 || do_img !== 32'h0) begin
      nerr++;
      $display("FAIL reset_data: re=%h im=%h, required 0 0", do_real, do_img);
    end
    nvec++;
    if (di_ready !== 1'b1) begin
      nerr++;
      $display("FAIL reset_ready: di_ready=%b, required 1", di_ready);
    end
    do_ready = 1'b1;
  endtask

  task automatic test_latency();
    apply(vt[0]);
    for (int s = 1; s <= 3; s++) begin
      step();
      idle();
      nvec++;
      if (do_valid !== (s == 3)) begin
        nerr++;
        $display("FAIL latency_valid: step %0d do_valid=%b, required %b", s, do_valid, (s == 3));
      end
    end
    $display("txn latency re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
    nvec++;
    if (do_real !== vt[0].er || do_img !== vt[0].ei || do_ovf !== vt[0].eo) begin
      nerr++;
      $display("FAIL latency_data: re=%h im=%h ovf=%b, required %h %h %b",
               do_real, do_img, do_ovf, vt[0].er, vt[0].ei, vt[0].eo);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int idx [2] = '{1, 2};
    int k = 0;
    for (int c = 0; c < 8; c++) begin
      if (c < 2) apply(vt[idx[c]]);
      else idle();
      step();
      if (do_valid) begin
        $display("txn b2b re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
        nvec++;
        if (k >= 2) begin
          nerr++;
          $display("FAIL b2b_extra: output %0d seen, required 2 outputs", k + 1);
        end else if (c + 1 != k + 3 || do_real !== vt[idx[k]].er || do_img !== vt[idx[k]].ei ||
                     do_ovf !== vt[idx[k]].eo) begin
          nerr++;
          $display("FAIL b2b_%0d: step %0d re=%h im=%h ovf=%b, required step %0d %h %h %b",
                   k, c + 1, do_real, do_img, do_ovf, k + 3, vt[idx[k]].er, vt[idx[k]].ei, vt[idx[k]].eo);
        end
        k++;
      end
    end
    nvec++;
    if (k != 2) begin
      nerr++;
      $display("FAIL b2b_count: got %0d outputs, required 2", k);
    end
  endtask

  task automatic test_conj_alternate();
    int idx [5] = '{3, 2, 3, 2, 3};
    int k = 0;
    for (int c = 0; c < 11; c++) begin
      if (c < 5) apply(vt[idx[c]]);
      else idle();
      step();
      if (do_valid) begin
        $display("txn conj re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
        nvec++;
        if (k >= 5) begin
          nerr++;
          $display("FAIL conj_extra: output %0d seen, required 5 outputs", k + 1);
        end else if (c + 1 != k + 3 || do_real !== vt[idx[k]].er || do_img !== vt[idx[k]].ei ||
                     do_ovf !== vt[idx[k]].eo) begin
          nerr++;
          $display("FAIL conj_%0d: step %0d re=%h im=%h ovf=%b, required step %0d %h %h %b",
                   k, c + 1, do_real, do_img, do_ovf, k + 3, vt[idx[k]].er, vt[idx[k]].ei, vt[idx[k]].eo);
        end
        k++;
      end
    end
    nvec++;
    if (k != 5) begin
      nerr++;
      $display("FAIL conj_count: got %0d outputs, required 5", k);
    end
  endtask

  task automatic test_round_sat();
    int k = 0;
    for (int c = 0; c < 14; c++) begin
      if (c < 8) apply(vt[4 + c]);
      else idle();
      step();
      if (do_valid) begin
        $display("txn round re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
        nvec++;
        if (k >= 8) begin
          nerr++;
          $display("FAIL round_extra: output %0d seen, required 8 outputs", k + 1);
        end else if (do_real !== vt[4 + k].er || do_img !== vt[4 + k].ei || do_ovf !== vt[4 + k].eo) begin
          nerr++;
          $display("FAIL round_vec%0d: re=%h im=%h ovf=%b, required %h %h %b",
                   4 + k, do_real, do_img, do_ovf, vt[4 + k].er, vt[4 + k].ei, vt[4 + k].eo);
        end
        k++;
      end else begin
        nvec++;
        if (do_ovf !== 1'b0) begin
          nerr++;
          $display("FAIL ovf_bubble: do_ovf=%b with do_valid=0, required 0", do_ovf);
        end
      end
    end
    nvec++;
    if (k != 8) begin
      nerr++;
      $display("FAIL round_count: got %0d outputs, required 8", k);
    end
  endtask

  task automatic test_backpressure();
    int          in_i = 0;
    int          exp_i = 0;
    int          stalls = 0;
    logic        acc;
    logic        hold_v = 1'b0;
    logic [31:0] hold_r = '0;
    logic [31:0] hold_m = '0;
    logic        hold_o = 1'b0;
    for (int c = 0; c < 24; c++) begin
      do_ready = !(c >= 4 && c < 8);
      if (in_i < 5) apply(vt[in_i]);
      else idle();
      #1;
      if (hold_v) begin
        nvec++;
        if (!do_valid || do_real !== hold_r || do_img !== hold_m || do_ovf !== hold_o) begin
          nerr++;
          $display("FAIL bp_stable: cycle %0d v=%b re=%h im=%h ovf=%b, required 1 %h %h %b",
                   c, do_valid, do_real, do_img, do_ovf, hold_r, hold_m, hold_o);
        end
      end
      if (do_valid && !do_ready) begin
        stalls++;
        nvec++;
        if (di_ready !== 1'b0) begin
          nerr++;
          $display("FAIL bp_ready: cycle %0d di_ready=%b while stalled, required 0", c, di_ready);
        end
      end
      if (do_valid && do_ready) begin
        $display("txn bp re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
        nvec++;
        if (exp_i >= 5) begin
          nerr++;
          $display("FAIL bp_dup: output %0d seen, required 5 outputs", exp_i + 1);
        end else if (do_real !== vt[exp_i].er || do_img !== vt[exp_i].ei || do_ovf !== vt[exp_i].eo) begin
          nerr++;
          $display("FAIL bp_order%0d: re=%h im=%h ovf=%b, required %h %h %b",
                   exp_i, do_real, do_img, do_ovf, vt[exp_i].er, vt[exp_i].ei, vt[exp_i].eo);
        end
        exp_i++;
      end
      acc    = di_valid && di_ready;
      hold_v = do_valid && !do_ready;
      hold_r = do_real;
      hold_m = do_img;
      hold_o = do_ovf;
      step();
      if (acc) in_i++;
    end
    do_ready = 1'b1;
    nvec++;
    if (exp_i != 5 || in_i != 5) begin
      nerr++;
      $display("FAIL bp_count: accepted %0d delivered %0d, required 5 5", in_i, exp_i);
    end
    nvec++;
    if (stalls != 4) begin
      nerr++;
      $display("FAIL bp_stalls: stalled cycles %0d, required 4", stalls);
    end
  endtask

  task automatic test_reset_flush();
    do_ready = 1'b1;
    apply(vt[1]);
    step();
    apply(vt[2]);
    step();
    apply(vt[3]);
    step();
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    nvec++;
    if (do_valid !== 1'b0 || do_real !== 32'h0 || do_img !== 32'h0 || do_ovf !== 1'b0) begin
      nerr++;
      $display("FAIL flush_out: v=%b re=%h im=%h ovf=%b, required 0 0 0 0", do_valid, do_real, do_img, do_ovf);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      nvec++;
      if (do_valid !== 1'b0) begin
        nerr++;
        $display("FAIL flush_stale: cycle %0d do_valid=%b, required 0", c, do_valid);
      end
    end
    apply(vt[2]);
    for (int s = 1; s <= 3; s++) begin
      step();
      idle();
      nvec++;
      if (do_valid !== (s == 3)) begin
        nerr++;
        $display("FAIL flush_lat: step %0d do_valid=%b, required %b", s, do_valid, (s == 3));
      end
    end
    $display("txn after_reset re=%h im=%h ovf=%b", do_real, do_img, do_ovf);
    nvec++;
    if (do_real !== vt[2].er || do_img !== vt[2].ei || do_ovf !== vt[2].eo) begin
      nerr++;
      $display("FAIL flush_data: re=%h im=%h ovf=%b, required %h %h %b",
               do_real, do_img, do_ovf, vt[2].er, vt[2].ei, vt[2].eo);
    end
    step();
  endtask

  initial begin
    load_table();
    rst = 1'b1;
    do_ready = 1'b1;
    idle();
    test_reset();
    test_latency();
    test_back_to_back();
    test_conj_alternate();
    test_round_sat();
    test_backpressure();
    test_reset_flush();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
